// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state codes, SPI mode encodings
// and default parameter values.
package spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEAD  = 3'd1;
  localparam state_t ST_XFER  = 3'd2;
  localparam state_t ST_TRAIL = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_SS = 4;
  localparam int DEF_DIV_W  = 8;

  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the SPI master: emits a one-cycle tick every
// clk_div+1 cycles while enabled; restarts from zero when a transfer is accepted.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == clk_div) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == clk_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: start/busy/done handshake, selectable slave,
// programmable SCK divider, all four CPOL/CPHA modes and either bit order.
//
//   state  | meaning
//   IDLE   | bus idle, ss_n high, sck at latched cpol, waiting for start
//   LEAD   | slave selected, first half-period before the first sck edge
//   XFER   | 2*DATA_W half-periods, sck toggling, shift/sample on edges
//   TRAIL  | sck back at cpol, slave still selected for one half-period
//   DONE   | one-cycle completion, rx_data valid, new start accepted
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_SS = DEF_NUM_SS,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  state_t              state_q,   state_d;
  logic                cpol_q,    cpol_d;
  logic                cpha_q,    cpha_d;
  logic                lsb_q,     lsb_d;
  logic [DIV_W-1:0]    div_q,     div_d;
  logic [DATA_W-1:0]   tx_sr_q,   tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q,   rx_sr_d;
  logic [EDGE_W-1:0]   edge_q,    edge_d;
  logic                sck_q,     sck_d;
  logic                mosi_q,    mosi_d;
  logic [NUM_SS-1:0]   ss_n_q,    ss_n_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;

  logic              tick;
  logic              accept;
  logic              shift;
  logic              sample;
  logic              lead_samples;
  logic [EDGE_W-1:0] edge_nxt;
  logic              ser_bit;
  logic [DATA_W-1:0] ser_next;

  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (sel == SS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (busy_q),
    .clk_div (div_q),
    .tick    (tick)
  );

  // Modes 0 and 2 sample on odd edges and shift on even ones; 1 and 3 swap.
  assign lead_samples = spi_mode(cpol_q, cpha_q) inside {MODE0, MODE2};
  assign edge_nxt     = edge_q + 1'b1;
  assign ser_bit      = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
  assign ser_next     = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    div_d     = div_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    edge_d    = edge_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    accept    = 1'b0;
    shift     = 1'b0;
    sample    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ss_n_d  = '1;
        mosi_d  = 1'b0;
        sck_d   = cpol_q;
        if (start) begin
          accept  = 1'b1;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          div_d   = clk_div;
          edge_d  = '0;
          sck_d   = cpol;
          busy_d  = 1'b1;
          ss_n_d  = ss_decode(ss_sel);
          state_d = ST_LEAD;
          if (cpha) begin
            tx_sr_d = tx_data;
          end else begin
            mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
            tx_sr_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
          end
        end
      end

      ST_LEAD: begin
        if (tick) begin
          sck_d   = ~sck_q;
          edge_d  = {{(EDGE_W-1){1'b0}}, 1'b1};
          state_d = ST_XFER;
          sample  = lead_samples;
          shift   = ~lead_samples;
        end
      end

      ST_XFER: begin
        if (tick) begin
          if (edge_q == LAST_EDGE) begin
            state_d = ST_TRAIL;
          end else begin
            sck_d  = ~sck_q;
            edge_d = edge_nxt;
            if (edge_nxt[0]) begin
              sample = lead_samples;
              shift  = ~lead_samples;
            end else begin
              sample = ~lead_samples;
              shift  = lead_samples && (edge_nxt != LAST_EDGE);
            end
          end
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          ss_n_d    = '1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sr_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ss_n_d  = '1;
        mosi_d  = 1'b0;
      end
    endcase

    if (shift) begin
      mosi_d  = ser_bit;
      tx_sr_d = ser_next;
    end
    // Shift in from the end opposite to transmission so rx matches the slave word.
    if (sample) begin
      rx_sr_d = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      div_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      edge_q    <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      div_q     <= div_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      edge_q    <= edge_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule
